// File: rtl/rtc_pkg.sv
// Shared field widths and range limits for the time-of-day counter and the
// alarm comparator that consumes its outputs.
package rtc_pkg;
  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
  localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;
  localparam logic [SEC_W-1:0]  MAX_SEC  = 6'd59;
endpackage

// File: rtl/rtc_prescaler.sv
// Divide-by-CLK_HZ counter: tc is high for one enabled cycle every CLK_HZ
// enabled cycles; clr restarts the count from 0 whether or not en is high.
module rtc_prescaler #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);
  localparam int CNT_W = $clog2(CLK_HZ);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc = en && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tc) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/rtc_time_counter.sv
// 24-hour binary time-of-day counter advanced once per second, with a
// range-checked load and registered second/midnight/error pulses.
module rtc_time_counter
  import rtc_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              time_set,
  input  logic [HOUR_W-1:0] set_hour_in,
  input  logic [MIN_W-1:0]  set_min_in,
  input  logic [SEC_W-1:0]  set_sec_in,
  output logic [HOUR_W-1:0] hour_rtc,
  output logic [MIN_W-1:0]  min_rtc,
  output logic [SEC_W-1:0]  sec_rtc,
  output logic              sec_tick,
  output logic              day_tick,
  output logic              set_err
);
  logic              tc;
  logic              set_ok;
  logic [HOUR_W-1:0] hour_q, hour_d;
  logic [MIN_W-1:0]  min_q, min_d;
  logic [SEC_W-1:0]  sec_q, sec_d;
  logic              sec_tick_q, sec_tick_d;
  logic              day_tick_q, day_tick_d;
  logic              set_err_q, set_err_d;

  assign set_ok = time_set && (set_hour_in <= MAX_HOUR) &&
                  (set_min_in <= MAX_MIN) && (set_sec_in <= MAX_SEC);

  rtc_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (run),
    .clr (set_ok),
    .tc  (tc)
  );

  // A valid load overrides the tick; a rejected load lets the tick through.
  always_comb begin
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    sec_tick_d = 1'b0;
    day_tick_d = 1'b0;
    set_err_d  = time_set && !set_ok;
    if (set_ok) begin
      hour_d = set_hour_in;
      min_d  = set_min_in;
      sec_d  = set_sec_in;
    end else if (tc) begin
      sec_tick_d = 1'b1;
      if (sec_q == MAX_SEC) begin
        sec_d = '0;
        if (min_q == MAX_MIN) begin
          min_d = '0;
          if (hour_q == MAX_HOUR) begin
            hour_d     = '0;
            day_tick_d = 1'b1;
          end else begin
            hour_d = hour_q + HOUR_W'(1);
          end
        end else begin
          min_d = min_q + MIN_W'(1);
        end
      end else begin
        sec_d = sec_q + SEC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hour_q     <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      sec_tick_q <= 1'b0;
      day_tick_q <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      sec_tick_q <= sec_tick_d;
      day_tick_q <= day_tick_d;
      set_err_q  <= set_err_d;
    end
  end

  assign hour_rtc = hour_q;
  assign min_rtc  = min_q;
  assign sec_rtc  = sec_q;
  assign sec_tick = sec_tick_q;
  assign day_tick = day_tick_q;
  assign set_err  = set_err_q;
endmodule

// File: tb/tb_rtc_time_counter.sv
// Directed bench for rtc_time_counter at CLK_HZ=4: reset, load/count,
// midnight rollover, rejected loads, load on terminal count, and stalls.
module tb_rtc_time_counter;
  localparam int CLK_HZ = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       time_set;
  logic [4:0] set_hour_in;
  logic [5:0] set_min_in;
  logic [5:0] set_sec_in;
  logic [4:0] hour_rtc;
  logic [5:0] min_rtc;
  logic [5:0] sec_rtc;
  logic       sec_tick;
  logic       day_tick;
  logic       set_err;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // {hour, min, sec, sec_tick, day_tick, set_err}
  logic [19:0] obs;
  logic [19:0] exp_v;
  assign obs = {hour_rtc, min_rtc, sec_rtc, sec_tick, day_tick, set_err};

  rtc_time_counter #(.CLK_HZ(CLK_HZ)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .time_set    (time_set),
    .set_hour_in (set_hour_in),
    .set_min_in  (set_min_in),
    .set_sec_in  (set_sec_in),
    .hour_rtc    (hour_rtc),
    .min_rtc     (min_rtc),
    .sec_rtc     (sec_rtc),
    .sec_tick    (sec_tick),
    .day_tick    (day_tick),
    .set_err     (set_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [19:0] pack(input int h, input int m, input int s,
                                       input bit st, input bit dt, input bit se);
    return {5'(h), 6'(m), 6'(s), st, dt, se};
  endfunction

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int h, input int m, input int s);
    time_set    = 1'b1;
    set_hour_in = 5'(h);
    set_min_in  = 6'(m);
    set_sec_in  = 6'(s);
    step();
    time_set    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1;
    time_set = 1'b1; set_hour_in = 5'd1; set_min_in = 6'd1; set_sec_in = 6'd1;
    for (int i = 0; i < 3; i++) step();
    exp_v = pack(0, 0, 0, 0, 0, 0);
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL reset_state: got %h want %h", obs, exp_v);
    else pass_cnt++;
    rst = 1'b0; time_set = 1'b0;
    for (int i = 0; i < 3; i++) step();
    exp_v = pack(0, 0, 0, 0, 0, 0);
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL reset_no_early_tick: got %h want %h", obs, exp_v);
    else pass_cnt++;
    step();
    exp_v = pack(0, 0, 1, 1, 0, 0);
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL reset_first_tick: got %h want %h", obs, exp_v);
    else pass_cnt++;
    step();
    exp_v = pack(0, 0, 1, 0, 0, 0);
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL reset_tick_one_cycle: got %h want %h", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_load_count();
    strobe(1, 2, 0);
    exp_v = pack(1, 2, 0, 0, 0, 0);
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL load_value: got %h want %h", obs, exp_v);
    else pass_cnt++;
    for (int k = 1; k <= 3; k++) begin
      for (int i = 0; i < 3; i++) step();
      exp_v = pack(1, 2, k - 1, 0, 0, 0);
      chk_cnt++;
      if (obs !== exp_v) $display("FAIL count_hold_%0d: got %h want %h", k, obs, exp_v);
      else pass_cnt++;
      step();
      exp_v = pack(1, 2, k, 1, 0, 0);
      chk_cnt++;
      if (obs !== exp_v) $display("FAIL count_tick_%0d: got %h want %h", k, obs, exp_v);
      else pass_cnt++;
    end
  endtask

  task automatic test_rollover();
    strobe(23, 59, 58);
    for (int i = 0; i < 4; i++) step();
    exp_v = pack(23, 59, 59, 1, 0, 0);
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL roll_59: got %h want %h", obs, exp_v);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) step();
    exp_v = pack(23, 59, 59, 0, 0, 0);
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL roll_hold: got %h want %h", obs, exp_v);
    else pass_cnt++;
    step();
    exp_v = pack(0, 0, 0, 1, 1, 0);
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL roll_midnight: got %h want %h", obs, exp_v);
    else pass_cnt++;
    step();
    exp_v = pack(0, 0, 0, 0, 0, 0);
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL roll_day_tick_pulse: got %h want %h", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_invalid_load();
    strobe(5, 6, 7);
    strobe(24, 0, 0);
    exp_v = pack(5, 6, 7, 0, 0, 1);
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL bad_hour: got %h want %h", obs, exp_v);
    else pass_cnt++;
    step();
    exp_v = pack(5, 6, 7, 0, 0, 0);
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL bad_err_pulse: got %h want %h", obs, exp_v);
    else pass_cnt++;
    strobe(0, 60, 0);
    exp_v = pack(5, 6, 7, 0, 0, 1);
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL bad_min: got %h want %h", obs, exp_v);
    else pass_cnt++;
    step();
    exp_v = pack(5, 6, 8, 1, 0, 0);
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL bad_phase_kept: got %h want %h", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_load_on_tc();
    for (int i = 0; i < 3; i++) step();
    strobe(10, 20, 30);
    exp_v = pack(10, 20, 30, 0, 0, 0);
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL tc_load_wins: got %h want %h", obs, exp_v);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) step();
    exp_v = pack(10, 20, 30, 0, 0, 0);
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL tc_load_hold: got %h want %h", obs, exp_v);
    else pass_cnt++;
    step();
    exp_v = pack(10, 20, 31, 1, 0, 0);
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL tc_load_next_tick: got %h want %h", obs, exp_v);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) step();
    strobe(0, 0, 61);
    exp_v = pack(10, 20, 32, 1, 0, 1);
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL tc_bad_load: got %h want %h", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) step();
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      exp_v = pack(10, 20, 32, 0, 0, 0);
      chk_cnt++;
      if (obs !== exp_v) $display("FAIL stall_hold_%0d: got %h want %h", i, obs, exp_v);
      else pass_cnt++;
    end
    run = 1'b1;
    step();
    exp_v = pack(10, 20, 32, 0, 0, 0);
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL stall_resume_hold: got %h want %h", obs, exp_v);
    else pass_cnt++;
    step();
    exp_v = pack(10, 20, 33, 1, 0, 0);
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL stall_delayed_tick: got %h want %h", obs, exp_v);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; time_set = 1'b0;
    set_hour_in = '0; set_min_in = '0; set_sec_in = '0;
    test_reset();
    test_load_count();
    test_rollover();
    test_invalid_load();
    test_load_on_tc();
    test_stall();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
